// File: rtl/nibble_add_sequencer_if.sv
// Request/response bundle for the nibble-serial adder: operand handshake in, result handshake out.
interface nibble_add_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero
  );
endinterface

// File: rtl/nibble_add_sequencer.sv
// Multi-cycle add/subtract: one 4-bit carry-lookahead block reused per nibble, LSB nibble first.
// All handshake and result outputs are registered; flags are captured on the last nibble.
module adder_4bits (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_c;

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign o_s    = w_p ^ w_c[3:0];
  assign o_co   = w_c[4];
endmodule

module nibble_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_add_sequencer_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_cin;
  logic             r_in_ready, r_out_valid;
  logic             r_carry, r_ovf, r_zero;

  logic             w_accept, w_last, w_co;
  logic [3:0]       w_a_nib, w_b_nib, w_sum;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_a_nib   = 4'(r_a >> {r_cnt, 2'b00});
  assign w_b_nib   = 4'(r_b >> {r_cnt, 2'b00});
  assign w_last    = (r_cnt == CW'(NIB - 1));
  // Result fills from the top so the LSB nibble lands at [3:0] after NIB shifts
  assign w_res_nxt = {w_sum, r_result[WIDTH-1:4]};

  adder_4bits u_add (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_ci (r_cin),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.in_valid && r_in_ready) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (r_out_valid && bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags follow the next state, so in_ready first rises one edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a   <= bus.op_a;
        r_b   <= bus.op_b ^ {WIDTH{bus.sub}};
        r_cin <= bus.sub;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_result <= w_res_nxt;
        r_cin    <= w_co;
        r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
        if (w_last) begin
          r_carry <= w_co;
          r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[3] != r_a[WIDTH-1]);
          r_zero  <= (w_res_nxt == '0);
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Scoreboard bench: drivers push hand-computed expectations, negedge monitors pop on each result handshake.
module tb_nibble_add_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_add_sequencer_if #(.WIDTH(32)) b32();
  nibble_add_sequencer_if #(.WIDTH(8))  b8();

  nibble_add_sequencer #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  nibble_add_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    logic [31:0] res;
    logic        c, v, z;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  bit   busy32 = 0, viol32 = 0, unst32 = 0, prev32 = 0;
  bit   busy8 = 0, prev8 = 0, rnd8 = 0;
  int   rise32 = 0, rise8 = 0;
  logic [34:0] snap32;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t       m;
    logic [7:0] bb;
    logic [8:0] t;
    bb    = s ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + 9'(s);
    m.res = {24'h0, t[7:0]};
    m.c   = t[8];
    m.v   = (a[7] == bb[7]) && (t[7] != a[7]);
    m.z   = (t[7:0] == 8'h0);
    m.acc = 0;
    return m;
  endfunction

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] er, input logic ec, input logic ev, input logic ez);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    b32.op_a = a; b32.op_b = b; b32.sub = s; b32.in_valid = 1'b1;
    while (!b32.in_ready && n < 100) begin @(negedge clk); n++; end
    check("w32_accept_timeout", 64'(n >= 100), 64'(0));
    if (n < 100) begin
      e.res = er; e.c = ec; e.v = ev; e.z = ez; e.acc = cyc + 1;
      q32.push_back(e);
      @(posedge clk); #1;
      busy32 = 1'b1;
    end
    b32.in_valid = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    b8.op_a = a; b8.op_b = b; b8.sub = s; b8.in_valid = 1'b1;
    while (!b8.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("w8_accept_timeout", 64'(1), 64'(0));
    else begin
      e = model8(a, b, s);
      e.acc = cyc + 1;
      q8.push_back(e);
      @(posedge clk); #1;
      busy8 = 1'b1;
    end
    b8.in_valid = 1'b0;
  endtask

  task automatic drain(input int w);
    int n = 0;
    while (((w == 32) ? (q32.size() != 0 || busy32) : (q8.size() != 0 || busy8)) && n < 300) begin
      @(negedge clk); n++;
    end
    check((w == 32) ? "w32_drain_timeout" : "w8_drain_timeout", 64'(n >= 300), 64'(0));
  endtask

  // 32-bit monitor: result, flags, latency, in_ready low while busy, stability under backpressure
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) prev32 = 1'b0;
    else begin
      if (busy32 && b32.in_ready) viol32 = 1'b1;
      if (b32.out_valid && !prev32) begin
        rise32 = cyc;
        snap32 = {b32.result, b32.carry, b32.overflow, b32.zero};
      end else if (b32.out_valid && snap32 !== {b32.result, b32.carry, b32.overflow, b32.zero})
        unst32 = 1'b1;
      if (b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) check("w32_spurious_out", 64'(1), 64'(0));
        else begin
          e = q32.pop_front();
          check("w32_result",   64'(b32.result),   64'(e.res));
          check("w32_carry",    64'(b32.carry),    64'(e.c));
          check("w32_overflow", 64'(b32.overflow), 64'(e.v));
          check("w32_zero",     64'(b32.zero),     64'(e.z));
          check("w32_latency",  64'(rise32 - e.acc), 64'(8));
          check("w32_in_ready_low_busy", 64'(viol32), 64'(0));
          check("w32_hold_stable", 64'(unst32), 64'(0));
        end
        busy32 = 1'b0; viol32 = 1'b0; unst32 = 1'b0;
      end
      prev32 = b32.out_valid;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) prev8 = 1'b0;
    else begin
      if (b8.out_valid && !prev8) rise8 = cyc;
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) check("w8_spurious_out", 64'(1), 64'(0));
        else begin
          e = q8.pop_front();
          check("w8_result_flags", 64'({b8.result, b8.carry, b8.overflow, b8.zero}),
                64'({e.res[7:0], e.c, e.v, e.z}));
          check("w8_latency", 64'(rise8 - e.acc), 64'(2));
        end
        busy8 = 1'b0;
      end
      prev8 = b8.out_valid;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    b8.out_ready = rnd8 ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    b32.in_valid = 0; b32.op_a = 0; b32.op_b = 0; b32.sub = 0; b32.out_ready = 1;
    b8.in_valid = 0;  b8.op_a = 0;  b8.op_b = 0;  b8.sub = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready",  64'(b32.in_ready),  64'(0));
    check("reset_out_valid", 64'(b32.out_valid), 64'(0));
    check("reset_result_flags", 64'({b32.result, b32.carry, b32.overflow, b32.zero}), 64'(0));
    rst_n = 1'b1;
    #1 check("in_ready_still_low_at_release", 64'(b32.in_ready), 64'(0));
    @(negedge clk);
    check("in_ready_one_edge_after_reset", 64'(b32.in_ready), 64'(1));

    op32(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0); drain(32);
    op32(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1); drain(32);
    op32(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0); drain(32);
    op32(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0); drain(32);
    op32(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0); drain(32);
    op32(32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1); drain(32);

    // Backpressure: result held 5 cycles while junk requests are offered
    @(posedge clk); #1 b32.out_ready = 1'b0;
    op32(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!b32.out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_out_valid_timeout", 64'(n >= 50), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b32.in_valid = i[0]; b32.op_a = $urandom; b32.op_b = $urandom; b32.sub = i[1];
      check("bp_in_ready_low", 64'(b32.in_ready), 64'(0));
    end
    b32.in_valid = 1'b0;
    @(posedge clk); #1 b32.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after_release", 64'(b32.in_ready), 64'(1));
    op32(32'hA0000000, 32'h60000001, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0); drain(32);

    // Asynchronous abort during RUN, then a clean op
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(b32.out_valid), 64'(0));
    check("abort_in_ready",  64'(b32.in_ready),  64'(0));
    check("abort_result_cleared", 64'(b32.result), 64'(0));
    q32.delete(); busy32 = 1'b0; viol32 = 1'b0; unst32 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op32(32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0); drain(32);

    // 8-bit unit: edge vectors then randomised traffic with gaps and backpressure
    op8(8'hFF, 8'h01, 1'b0); op8(8'h7F, 8'h01, 1'b0); op8(8'h80, 8'h01, 1'b1);
    op8(8'h05, 8'h07, 1'b1); op8(8'h5A, 8'h5A, 1'b1); drain(8);
    rnd8 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end
    drain(8);
    rnd8 = 1'b0;
    drain(8);
    check("w32_queue_empty", 64'(q32.size()), 64'(0));
    check("w8_queue_empty",  64'(q8.size()),  64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
